// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, data port and shared memory port.
// "master" is the arbiter's view; "slave" is the requesters' and memory's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_wstrb;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  m_req;
  logic                  m_we;
  logic [ADDR_W-1:0]     m_addr;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W/8-1:0]   m_wstrb;
  logic                  m_ack;
  logic [DATA_W-1:0]     m_rdata;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_addr, m_wdata, m_wstrb,
    input  m_ack, m_rdata
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_addr, m_wdata, m_wstrb,
    output m_ack, m_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch vs. load/store: data priority with a fetch
// starvation guard, one access in flight. Define ARB_PERF_CNT_EN for perf counters.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_port_arbiter_if.master    bus,
  output logic                  busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_conflict_cnt,
  output logic [31:0]           perf_wait_cnt
`endif
);

  localparam int SW    = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             pick_i, pick_d, done;
  logic             conflict;

  assign conflict = (state == IDLE) && bus.if_req && bus.d_req;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Data wins a conflict until fetch has lost LIMIT times in a row.
  always_comb begin
    state_nxt = state;
    pick_i    = 1'b0;
    pick_d    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.d_req && (!bus.if_req || starve_cnt < LIMIT)) begin
          pick_d    = 1'b1;
          state_nxt = BUSY_D;
        end else if (bus.if_req) begin
          pick_i    = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.m_ack) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (pick_i) begin
      starve_cnt <= '0;
    end else if (pick_d && bus.if_req && starve_cnt < LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Memory port: fields captured at the IDLE decision, held until m_ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.m_req   <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.m_wstrb <= '0;
    end else if (pick_d) begin
      bus.m_req   <= 1'b1;
      bus.m_we    <= bus.d_we;
      bus.m_addr  <= bus.d_addr;
      bus.m_wdata <= bus.d_we ? bus.d_wdata : '0;
      bus.m_wstrb <= bus.d_we ? bus.d_wstrb : SW'(0);
    end else if (pick_i) begin
      bus.m_req   <= 1'b1;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= bus.if_addr;
      bus.m_wdata <= '0;
      bus.m_wstrb <= '0;
    end else if (done) begin
      bus.m_req   <= 1'b0;
    end
  end

  // Return path routed to whichever requester owns the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.if_gnt    <= 1'b0;
      bus.d_gnt     <= 1'b0;
      bus.if_rvalid <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
    end else begin
      bus.if_gnt    <= pick_i;
      bus.d_gnt     <= pick_d;
      bus.if_rvalid <= done && (state == BUSY_I);
      bus.d_rvalid  <= done && (state == BUSY_D);
      if (done && state == BUSY_I) bus.if_rdata <= bus.m_we ? '0 : bus.m_rdata;
      if (done && state == BUSY_D) bus.d_rdata  <= bus.m_we ? '0 : bus.m_rdata;
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_conflict_cnt <= '0;
      perf_wait_cnt     <= '0;
    end else begin
      if (conflict)                  perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      if (bus.m_req && !bus.m_ack)   perf_wait_cnt     <= perf_wait_cnt + 32'd1;
    end
  end
`else
  logic unused_conflict;
  assign unused_conflict = conflict;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: requests push expected grants/completions
// into queues, an independent negedge monitor pops and compares.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_conflict_cnt, perf_wait_cnt;
`endif

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_conflict_cnt (perf_conflict_cnt),
    .perf_wait_cnt     (perf_wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  // memory model: ack after wait_cfg stall cycles, data derived from address
  int   wait_cfg = 0;
  int   wcnt;
  logic spur_ack = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h100) ? 32'h00500093 : {a[15:0], ~a[15:0]};
  endfunction

  assign bus.m_ack   = spur_ack | (bus.m_req && wcnt == wait_cfg);
  assign bus.m_rdata = mem_rd(bus.m_addr);

  always @(posedge clk or posedge rst) begin
    if (rst)                         wcnt <= 0;
    else if (bus.m_req && !bus.m_ack) wcnt <= wcnt + 1;
    else                             wcnt <= 0;
  end

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } gexp_t;

  gexp_t       gq[$];
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: got event expected none", name);
  endtask

  gexp_t mon_g;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.if_gnt || bus.d_gnt) begin
        if (gq.size() == 0) unexpected("unexpected_gnt");
        else begin
          mon_g = gq.pop_front();
          chkb("gnt_owner",  bus.d_gnt, mon_g.is_d);
          chkb("gnt_single", bus.if_gnt & bus.d_gnt, 1'b0);
          chkb("gnt_m_req",  bus.m_req, 1'b1);
          chk ("gnt_m_addr", bus.m_addr, mon_g.addr);
          chkb("gnt_m_we",   bus.m_we, mon_g.we);
          chk ("gnt_m_wdata", bus.m_wdata, mon_g.wdata);
          chk ("gnt_m_wstrb", {28'h0, bus.m_wstrb}, {28'h0, mon_g.wstrb});
        end
      end
      if (bus.if_rvalid) begin
        if (iq.size() == 0) unexpected("unexpected_if_rvalid");
        else chk("if_rdata", bus.if_rdata, iq.pop_front());
      end
      if (bus.d_rvalid) begin
        if (dq.size() == 0) unexpected("unexpected_d_rvalid");
        else chk("d_rdata", bus.d_rdata, dq.pop_front());
      end
    end
  end

  task automatic do_req(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb, output int lat);
    gexp_t g;
    logic  seen;
    g.is_d  = is_d;
    g.addr  = addr;
    g.we    = we;
    g.wdata = we ? wdata : 32'h0;
    g.wstrb = we ? wstrb : 4'h0;
    gq.push_back(g);
    if (is_d) dq.push_back(we ? 32'h0 : mem_rd(addr));
    else      iq.push_back(mem_rd(addr));
    @(negedge clk);
    if (is_d) begin
      bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_wstrb = wstrb; bus.d_req = 1'b1;
    end else begin
      bus.if_addr = addr; bus.if_req = 1'b1;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      seen = is_d ? bus.d_gnt : bus.if_gnt;
    end while (!seen && lat < 50);
    chkb("gnt_seen", seen, 1'b1);
    if (is_d) bus.d_req = 1'b0;
    else      bus.if_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 50);
    chkb("idle_reached", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, n, mreq_cyc, g, cyc;
    logic ok;
    bus.if_req = 0; bus.if_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_wstrb = 0;
    #1 rst = 1'b1;
    #1;
    chkb("rst_if_gnt",    bus.if_gnt, 1'b0);
    chkb("rst_if_rvalid", bus.if_rvalid, 1'b0);
    chk ("rst_if_rdata",  bus.if_rdata, 32'h0);
    chkb("rst_d_gnt",     bus.d_gnt, 1'b0);
    chkb("rst_d_rvalid",  bus.d_rvalid, 1'b0);
    chk ("rst_d_rdata",   bus.d_rdata, 32'h0);
    chkb("rst_m_req",     bus.m_req, 1'b0);
    chk ("rst_m_addr",    bus.m_addr, 32'h0);
    chkb("rst_busy",      busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: zero-wait fetch
    do_req(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, lat);
    chk("t1_gnt_latency", lat, 1);
    @(negedge clk);
    chkb("t1_if_rvalid", bus.if_rvalid, 1'b1);
    chk ("t1_if_rdata",  bus.if_rdata, 32'h00500093);
    @(negedge clk);

    // 2: store with 3 wait cycles
    wait_cfg = 3;
    do_req(1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 4'hF, lat);
    n = 0; mreq_cyc = 1; ok = 1'b1;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (bus.d_rvalid) break;
      if (bus.m_req) begin
        mreq_cyc++;
        if (bus.m_addr !== 32'h2004 || bus.m_wdata !== 32'hDEADBEEF ||
            bus.m_wstrb !== 4'hF || bus.m_we !== 1'b1) ok = 1'b0;
      end
    end
    chk ("t2_rvalid_latency", n, 4);
    chk ("t2_m_req_cycles", mreq_cyc, 4);
    chkb("t2_m_stable", ok, 1'b1);
    chk ("t2_d_rdata", bus.d_rdata, 32'h0);
    wait_cfg = 0;
    @(negedge clk);

    // 5: spurious ack while idle
    spur_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chkb("t5_busy",   busy, 1'b0);
      chkb("t5_m_req",  bus.m_req, 1'b0);
      chkb("t5_rvalid", bus.if_rvalid | bus.d_rvalid, 1'b0);
    end
    spur_ack = 1'b0;
    @(negedge clk);

    // 4: reset in the middle of a data access
    wait_cfg = 10;
    do_req(1'b1, 1'b0, 32'h4000, 32'h0, 4'h0, lat);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chkb("t4_m_req",    bus.m_req, 1'b0);
    chkb("t4_busy",     busy, 1'b0);
    chkb("t4_gnt",      bus.d_gnt | bus.if_gnt, 1'b0);
    chkb("t4_rvalid",   bus.d_rvalid | bus.if_rvalid, 1'b0);
    dq.delete();
    repeat (2) @(negedge clk);
    wait_cfg = 0;
    rst = 1'b0;
    ok = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (bus.d_rvalid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chkb("t4_quiet_after_release", ok, 1'b1);

    // 3: continuous contention -> D,D,D,D,IF repeating
    for (int k = 0; k < 10; k++) begin
      gexp_t e;
      e.is_d  = (k % 5) != 4;
      e.addr  = e.is_d ? 32'h3000 : 32'h200;
      e.we    = 1'b0;
      e.wdata = 32'h0;
      e.wstrb = 4'h0;
      gq.push_back(e);
      if (e.is_d) dq.push_back(mem_rd(32'h3000));
      else        iq.push_back(mem_rd(32'h200));
    end
    @(negedge clk);
    bus.if_addr = 32'h200;
    bus.d_addr = 32'h3000; bus.d_we = 1'b0; bus.d_wdata = 32'h0; bus.d_wstrb = 4'h0;
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    g = 0; cyc = 0;
    while (g < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.if_gnt || bus.d_gnt) g++;
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    chk("t3_grant_count", g, 10);
    wait_idle();

    // 6: one load with 7 stall cycles
    wait_cfg = 7;
    do_req(1'b1, 1'b0, 32'h5000, 32'h0, 4'h0, lat);
    wait_idle();
    wait_cfg = 0;
    @(negedge clk);
`ifdef ARB_PERF_CNT_EN
    chk("t6_perf_conflict", perf_conflict_cnt, 32'd10);
    chk("t6_perf_wait",     perf_wait_cnt, 32'd7);
`endif

    repeat (5) @(negedge clk);
    chk("gnt_queue_drained", gq.size(), 0);
    chk("if_queue_drained",  iq.size(), 0);
    chk("d_queue_drained",   dq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
